// File: rtl/return_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
// No logic latency; pure definitions.
// No flow control; the stack accepts an operation every cycle.
package return_stack_pkg;

    localparam int PC_WIDTH     = 10;
    localparam int RSTACK_DEPTH = 8;

    // Operation requested in a cycle; push+pop together means "replace top".
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        op = OP_NONE;
        if (push && pop) begin
            op = OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/return_stack_if.sv
// Request/status bundle between the PC logic and the return-address stack.
// No latency of its own; pop_data/status are combinational from stack state.
// No backpressure: requests are always accepted, errors only raise sticky flags.
interface return_stack_if #(
    parameter int WIDTH = return_stack_pkg::PC_WIDTH,
    parameter int DEPTH = return_stack_pkg::RSTACK_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clr_err;
    logic [WIDTH-1:0] pop_data;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    // Requester side (PC logic / bench).
    modport master (
        output push, pop, push_data, clr_err,
        input  pop_data, empty, full, count, ovf, udf
    );

    // Stack side.
    modport slave (
        input  push, pop, push_data, clr_err,
        output pop_data, empty, full, count, ovf, udf
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is zero-latency.
// No flow control; contents are not reset.
module stack_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: addresses stay below DEPTH, so non-power-of-two depths are safe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Return-address stack with count, full/empty, sticky ovf/udf and saturate-or-wrap overflow.
// Zero-latency top-of-stack read; state changes on the next rising edge.
// Never stalls: illegal pushes/pops set a sticky flag and are dropped (or wrap if WRAP=1).
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RSTACK_DEPTH,
    parameter bit WRAP  = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave rs
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] SP_MAX   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [PW-1:0]    sp_inc, sp_dec;
    logic             is_empty, is_full;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [WIDTH-1:0] top;
    op_e              op;

    // Circular pointer neighbours; sp_dec is also the top-of-stack slot.
    always_comb begin
        sp_inc = (sp_q == SP_MAX) ? '0 : sp_q + 1'b1;
        sp_dec = (sp_q == '0) ? SP_MAX : sp_q - 1'b1;
    end

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    assign op       = decode_op(rs.push, rs.pop);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (rs.push_data),
        .raddr_i (sp_dec),
        .rdata_o (top)
    );

    // Next-state for pointer, occupancy, RAM write and sticky error flags.
    always_comb begin
        logic ovf_set;
        logic udf_set;
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    sp_d    = sp_inc;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_set = 1'b1;
                    // Wrapping overwrites the oldest slot, which is exactly mem[sp] when full.
                    if (WRAP) begin
                        we   = 1'b1;
                        sp_d = sp_inc;
                    end
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    sp_d    = sp_dec;
                    count_d = count_q - 1'b1;
                end else begin
                    udf_set = 1'b1;
                end
            end
            OP_REPL: begin
                if (!is_empty) begin
                    we    = 1'b1;
                    waddr = sp_dec;
                end else begin
                    // Nothing to pop: flag it, but still honour the push.
                    udf_set = 1'b1;
                    we      = 1'b1;
                    sp_d    = sp_inc;
                    count_d = CW'(1);
                end
            end
            default: begin
            end
        endcase
        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~rs.clr_err);
        udf_d = udf_set | (udf_q & ~rs.clr_err);
    end

    // State registers; async reset empties the stack without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign rs.pop_data = is_empty ? '0 : top;
    assign rs.empty    = is_empty;
    assign rs.full     = is_full;
    assign rs.count    = count_q;
    assign rs.ovf      = ovf_q;
    assign rs.udf      = udf_q;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: WRAP=0 and WRAP=1 instances driven with identical stimulus.
// Outputs are compared every cycle against a queue-based model, plus literal checks.
// Randomized phases push the stack into full/empty corners repeatedly.
module tb_return_stack;
    localparam int W = 10;
    localparam int D = 8;
    localparam int CW = $clog2(D + 1);

    typedef logic [W-1:0] dq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    return_stack_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    return_stack_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    return_stack #(.WIDTH(W), .DEPTH(D), .WRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .rs(if0.slave));
    return_stack #(.WIDTH(W), .DEPTH(D), .WRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .rs(if1.slave));

    int  vectors = 0;
    int  miscompares = 0;
    dq_t q0, q1;
    bit  ov0, ud0, ov1, ud1;
    bit  cur_pu, cur_po, cur_cl;
    logic [W-1:0] cur_d;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input logic [W-1:0] pd, input logic em, input logic fu,
                              input logic [CW-1:0] cnt, input logic ov, input logic ud,
                              input dq_t q, input bit mov, input bit mud);
        int n;
        logic [W-1:0] exp_pd;
        n = q.size();
        exp_pd = '0;
        if (n > 0) exp_pd = q[n-1];
        cmp({tag, ".pop_data"}, pd, exp_pd);
        cmp({tag, ".empty"}, em, (n == 0));
        cmp({tag, ".full"}, fu, (n == D));
        cmp({tag, ".count"}, cnt, n);
        cmp({tag, ".ovf"}, ov, mov);
        cmp({tag, ".udf"}, ud, mud);
    endtask

    task automatic check_all();
        check_inst("w0", if0.pop_data, if0.empty, if0.full, if0.count, if0.ovf, if0.udf, q0, ov0, ud0);
        check_inst("w1", if1.pop_data, if1.empty, if1.full, if1.count, if1.ovf, if1.udf, q1, ov1, ud1);
    endtask

    // Stack semantics stated directly on a queue whose back is the top of stack.
    task automatic model_step(input bit wrap, input bit pu, input bit po, input logic [W-1:0] d,
                              input bit cl, inout dq_t q, inout bit ov, inout bit ud);
        bit os, us;
        os = 1'b0;
        us = 1'b0;
        if (pu && !po) begin
            if (q.size() < D) begin
                q.push_back(d);
            end else begin
                os = 1'b1;
                if (wrap) begin
                    void'(q.pop_front());
                    q.push_back(d);
                end
            end
        end else if (po && !pu) begin
            if (q.size() > 0) void'(q.pop_back());
            else us = 1'b1;
        end else if (pu && po) begin
            if (q.size() > 0) begin
                q[q.size()-1] = d;
            end else begin
                us = 1'b1;
                q.push_back(d);
            end
        end
        ov = os | (ov & !cl);
        ud = us | (ud & !cl);
    endtask

    task automatic drive(input bit pu, input bit po, input logic [W-1:0] d, input bit cl);
        cur_pu = pu; cur_po = po; cur_d = d; cur_cl = cl;
        if0.push = pu; if0.pop = po; if0.push_data = d; if0.clr_err = cl;
        if1.push = pu; if1.pop = po; if1.push_data = d; if1.clr_err = cl;
    endtask

    // One clock cycle: apply inputs, check (optionally pinning pop_data), advance model.
    task automatic cycle(input bit pu, input bit po, input logic [W-1:0] d, input bit cl,
                         input int e0, input int e1);
        drive(pu, po, d, cl);
        #1;
        check_all();
        if (e0 >= 0) cmp("lit.w0.pop_data", if0.pop_data, e0);
        if (e1 >= 0) cmp("lit.w1.pop_data", if1.pop_data, e1);
        @(posedge clk);
        model_step(1'b0, cur_pu, cur_po, cur_d, cur_cl, q0, ov0, ud0);
        model_step(1'b1, cur_pu, cur_po, cur_d, cur_cl, q1, ov1, ud1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Reset asserted between edges while a push is pending; must take effect at once.
    task automatic async_reset_midburst(input logic [W-1:0] d);
        drive(1'b1, 1'b0, d, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        cmp("rst.w0.empty", if0.empty, 1);
        cmp("rst.w0.count", if0.count, 0);
        cmp("rst.w1.empty", if1.empty, 1);
        cmp("rst.w1.pop_data", if1.pop_data, 0);
        q0.delete(); q1.delete();
        ov0 = 0; ud0 = 0; ov1 = 0; ud1 = 0;
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int ph;
        drive(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        // Reset state, literal.
        cmp("reset.empty", if0.empty, 1);
        cmp("reset.full", if0.full, 0);
        cmp("reset.count", if0.count, 0);
        cmp("reset.pop_data", if0.pop_data, 0);
        cmp("reset.ovf", if0.ovf, 0);
        cmp("reset.udf", if0.udf, 0);
        reset = 1'b0;

        // LIFO order with zero-latency pop data.
        cycle(1, 0, 10'h001, 0, -1, -1);
        cycle(1, 0, 10'h002, 0, -1, -1);
        cycle(1, 0, 10'h003, 0, -1, -1);
        cycle(0, 1, '0, 0, 'h003, 'h003);
        cycle(0, 1, '0, 0, 'h002, 'h002);
        cycle(0, 1, '0, 0, 'h001, 'h001);
        cmp("s2.empty", if0.empty, 1);

        // Nine pushes into an 8-deep stack: saturate vs wrap.
        for (int k = 0; k < 9; k++) cycle(1, 0, 10'h010 + 10'(k), 0, -1, -1);
        cmp("s3.full", if0.full, 1);
        cmp("s3.ovf", if0.ovf, 1);
        cmp("s3.count", if0.count, 8);
        cmp("s3.top", if0.pop_data, 'h017);
        cmp("s4.ovf", if1.ovf, 1);
        cmp("s4.count", if1.count, 8);
        cmp("s4.top", if1.pop_data, 'h018);
        for (int k = 0; k < 8; k++) cycle(0, 1, '0, 0, 'h017 - k, 'h018 - k);
        cycle(0, 0, '0, 1, -1, -1);

        // Replace-top via simultaneous push+pop.
        cycle(1, 0, 10'h0A0, 0, -1, -1);
        cycle(1, 0, 10'h0B0, 0, -1, -1);
        cycle(1, 1, 10'h0C0, 0, 'h0B0, 'h0B0);
        cmp("s5.count", if0.count, 2);
        cmp("s5.top", if0.pop_data, 'h0C0);
        cycle(0, 1, '0, 0, 'h0C0, 'h0C0);
        cmp("s5.after_pop", if0.pop_data, 'h0A0);
        cycle(0, 1, '0, 0, 'h0A0, 'h0A0);

        // Underflow stickiness and clear priority.
        cycle(0, 1, '0, 0, -1, -1);
        cmp("s6.udf_set", if0.udf, 1);
        cycle(0, 1, '0, 1, -1, -1);
        cmp("s6.udf_held", if0.udf, 1);
        cycle(0, 0, '0, 1, -1, -1);
        cmp("s6.udf_clr", if0.udf, 0);
        cycle(1, 0, 10'h155, 0, -1, -1);
        cycle(1, 0, 10'h2AA, 0, -1, -1);
        async_reset_midburst(10'h3FF);

        // Randomized phases: push-heavy, pop-heavy, mixed.
        for (int i = 0; i < 1500; i++) begin
            bit pu, po, cl;
            ph = (i / 60) % 3;
            if (ph == 0) begin
                pu = ($urandom_range(0, 99) < 75);
                po = ($urandom_range(0, 99) < 20);
            end else if (ph == 1) begin
                pu = ($urandom_range(0, 99) < 20);
                po = ($urandom_range(0, 99) < 75);
            end else begin
                pu = $urandom_range(0, 1);
                po = $urandom_range(0, 1);
            end
            cl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) async_reset_midburst(W'($urandom));
            else cycle(pu, po, W'($urandom), cl, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
